// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and sizing for the decode sequencer
package decode_pkg;

  localparam int WINDOW_BYTES = 16;
  localparam int FETCH_BYTES  = 4;
  localparam int MAX_INSN_LEN = 15;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    ERROR   = 2'd2
  } seq_state_t;

  // Index 0 is the first byte of the next instruction.
  typedef logic [0:WINDOW_BYTES-1][7:0] byte_window_t;

endpackage

// File: rtl/decode_sequencer_if.sv
// rtl/decode_sequencer_if.sv - prefetch and decoder handshake bundle
interface decode_sequencer_if;
  import decode_pkg::*;

  logic                     i_flush;
  logic                     i_fetch_valid;
  logic [8*FETCH_BYTES-1:0] i_fetch_data;
  logic [2:0]               i_fetch_count;
  logic                     o_fetch_ready;
  byte_window_t             o_instruction;
  logic [4:0]               o_byte_count;
  logic                     o_window_valid;
  logic                     i_decode_done;
  logic [3:0]               i_decode_length;
  logic                     i_decode_need_more;
  logic                     o_error;

  modport master (
    output i_flush, i_fetch_valid, i_fetch_data, i_fetch_count,
    output i_decode_done, i_decode_length, i_decode_need_more,
    input  o_fetch_ready, o_instruction, o_byte_count, o_window_valid, o_error
  );

  modport slave (
    input  i_flush, i_fetch_valid, i_fetch_data, i_fetch_count,
    input  i_decode_done, i_decode_length, i_decode_need_more,
    output o_fetch_ready, o_instruction, o_byte_count, o_window_valid, o_error
  );

endinterface

// File: rtl/decode_window_shifter.sv
// rtl/decode_window_shifter.sv - retire consumed bytes and append fetched bytes
module decode_window_shifter
  import decode_pkg::*;
(
  input  byte_window_t             window,
  input  logic [4:0]               count,
  input  logic [3:0]               consume_len,
  input  logic [8*FETCH_BYTES-1:0] fetch_data,
  input  logic [2:0]               fetch_count,
  output byte_window_t             next_window,
  output logic [4:0]               next_count
);

  logic [FETCH_BYTES-1:0][7:0] fetch_bytes;
  logic [4:0]                  keep_count;

  assign fetch_bytes = fetch_data;
  assign keep_count  = count - {1'b0, consume_len};
  assign next_count  = keep_count + {2'b00, fetch_count};

  // Surviving bytes slide down by consume_len, fetched bytes land right after them, the rest is zero.
  always_comb begin
    next_window = '0;
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      if (5'(i) < keep_count) begin
        next_window[i] = window[4'(5'(i) + {1'b0, consume_len})];
      end else if ((5'(i) - keep_count) < {2'b00, fetch_count}) begin
        next_window[i] = fetch_bytes[2'(5'(i) - keep_count)];
      end
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - instruction window sequencer between prefetch and decode
module decode_sequencer
  import decode_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  decode_sequencer_if.slave bus
);

  seq_state_t   state, state_nxt;
  byte_window_t window, window_nxt;
  logic [4:0]   count, count_nxt;
  logic [4:0]   need, need_nxt;

  logic       fetch_ready;
  logic       fetch_accept;
  logic       done;
  logic       need_more;
  logic       length_bad;
  logic       proto_error;
  logic [3:0] consume_len;
  logic [2:0] fetch_len;

  // Ready depends only on registered count/state so prefetch never sees a decoder-driven path.
  assign fetch_ready  = (count <= 5'(WINDOW_BYTES - FETCH_BYTES)) && (state != ERROR);
  assign fetch_accept = bus.i_fetch_valid && fetch_ready;

  assign done        = (state == PRESENT) && bus.i_decode_done;
  assign need_more   = (state == PRESENT) && bus.i_decode_need_more;
  assign length_bad  = (bus.i_decode_length == 4'd0) || ({1'b0, bus.i_decode_length} > count);
  assign proto_error = (done && need_more) || (done && length_bad) ||
                       (need_more && (count > 5'(MAX_INSN_LEN)));

  // An erroring cycle consumes nothing; an accepted fetch is still honoured.
  assign consume_len = (done && !proto_error) ? bus.i_decode_length : 4'd0;
  assign fetch_len   = fetch_accept ? bus.i_fetch_count : 3'd0;

  decode_window_shifter u_shifter (
    .window      (window),
    .count       (count),
    .consume_len (consume_len),
    .fetch_data  (bus.i_fetch_data),
    .fetch_count (fetch_len),
    .next_window (window_nxt),
    .next_count  (count_nxt)
  );

  // Next state and need threshold from decoder feedback and the post-update byte count.
  always_comb begin
    state_nxt = state;
    need_nxt  = need;
    case (state)
      FILL: begin
        if ((count_nxt >= need) || (count_nxt == 5'(WINDOW_BYTES))) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (proto_error) begin
          state_nxt = ERROR;
        end else if (done) begin
          need_nxt  = 5'd1;
          state_nxt = (count_nxt != 5'd0) ? PRESENT : FILL;
        end else if (need_more) begin
          need_nxt  = count + 5'd1;
          state_nxt = FILL;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Window registers; flush behaves like reset and wins over fetch and decode.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_flush) begin
      state  <= FILL;
      window <= '0;
      count  <= 5'd0;
      need   <= 5'd1;
    end else begin
      state  <= state_nxt;
      window <= window_nxt;
      count  <= count_nxt;
      need   <= need_nxt;
      assert (count_nxt <= 5'(WINDOW_BYTES));
    end
  end

  assign bus.o_fetch_ready  = fetch_ready;
  assign bus.o_instruction  = window;
  assign bus.o_byte_count   = count;
  assign bus.o_window_valid = (state == PRESENT);
  assign bus.o_error        = (state == ERROR);

endmodule

// File: tb/tb_decode_sequencer.sv
// tb/tb_decode_sequencer.sv - self-checking bench for decode_sequencer
module tb_decode_sequencer;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  decode_sequencer_if bus();

  decode_sequencer dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [7:0] m_q[$];
  bit         m_present = 1'b0;
  bit         m_err     = 1'b0;
  int         m_need    = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit fl, input bit fv, input logic [31:0] fd, input logic [2:0] fc,
                       input bit dd, input logic [3:0] dl, input bit nm);
    bus.i_flush            = fl;
    bus.i_fetch_valid      = fv;
    bus.i_fetch_data       = fd;
    bus.i_fetch_count      = fc;
    bus.i_decode_done      = dd;
    bus.i_decode_length    = dl;
    bus.i_decode_need_more = nm;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the window is a byte queue, presentation is a flag, need is a plain threshold.
  always @(posedge clk) begin : model_step
    int  sz;
    int  len;
    bit  acc;
    bit  was_present;
    bit  dn;
    bit  nm;
    bit  consumed;
    sz          = m_q.size();
    was_present = m_present;
    consumed    = 1'b0;
    if (rst || bus.i_flush) begin
      m_q.delete();
      m_need    = 1;
      m_present = 1'b0;
      m_err     = 1'b0;
    end else if (!m_err) begin
      acc = bus.i_fetch_valid && (sz <= WINDOW_BYTES - FETCH_BYTES);
      dn  = bus.i_decode_done;
      nm  = bus.i_decode_need_more;
      len = int'(bus.i_decode_length);
      if (was_present) begin
        if ((dn && nm) || (dn && (len == 0 || len > sz)) || (nm && sz == WINDOW_BYTES)) begin
          m_err     = 1'b1;
          m_present = 1'b0;
        end else if (dn) begin
          repeat (len) void'(m_q.pop_front());
          m_need   = 1;
          consumed = 1'b1;
        end else if (nm) begin
          m_need    = sz + 1;
          m_present = 1'b0;
        end
      end
      if (acc) begin
        for (int k = 0; k < int'(bus.i_fetch_count); k++) begin
          m_q.push_back(bus.i_fetch_data[8*k +: 8]);
        end
      end
      if (consumed) begin
        m_present = (m_q.size() > 0);
      end else if (!was_present && !m_err) begin
        if (m_q.size() >= m_need || m_q.size() == WINDOW_BYTES) m_present = 1'b1;
      end
    end
  end

  // Compare every DUT output against the model each cycle, away from the active edge.
  always @(negedge clk) begin : compare
    logic [0:15][7:0] exp_w;
    if (chk_en) begin
      exp_w = '0;
      for (int i = 0; i < m_q.size(); i++) exp_w[i] = m_q[i];
      check("byte_count",   bus.o_byte_count,   m_q.size());
      check("window",       bus.o_instruction,  exp_w);
      check("window_valid", bus.o_window_valid, m_present);
      check("fetch_ready",  bus.o_fetch_ready,  (m_q.size() <= WINDOW_BYTES - FETCH_BYTES) && !m_err);
      check("error",        bus.o_error,        m_err);
    end
  end

  initial begin
    int  sz;
    int  r;
    int  maxl;
    bit  fl;
    bit  fv;
    bit  dd;
    bit  nm;
    logic [3:0] dl;

    idle();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("lit_reset_count", bus.o_byte_count, 5'd0);
    check("lit_reset_valid", bus.o_window_valid, 1'b0);
    check("lit_reset_ready", bus.o_fetch_ready, 1'b1);
    check("lit_reset_error", bus.o_error, 1'b0);
    check("lit_reset_window", bus.o_instruction, 128'h0);

    // basic fill
    drive(1'b0, 1'b1, 32'h90909090, 3'd4, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    check("lit_fill_count", bus.o_byte_count, 5'd4);
    check("lit_fill_valid", bus.o_window_valid, 1'b1);
    check("lit_fill_b0", bus.o_instruction[0], 8'h90);
    check("lit_fill_b4", bus.o_instruction[4], 8'h00);
    check("lit_fill_window", bus.o_instruction, {32'h90909090, 96'h0});

    // need more
    drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h0000bbaa, 3'd2, 1'b0, 4'd0, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b1); tick();
    idle();
    check("lit_nm_valid", bus.o_window_valid, 1'b0);
    check("lit_nm_count", bus.o_byte_count, 5'd2);
    drive(1'b0, 1'b1, 32'h000000cc, 3'd1, 1'b0, 4'd0, 1'b0); tick();
    idle();
    check("lit_nm_valid2", bus.o_window_valid, 1'b1);
    check("lit_nm_count2", bus.o_byte_count, 5'd3);
    check("lit_nm_b2", bus.o_instruction[2], 8'hcc);

    // consume plus fetch in one cycle
    drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h13121110, 3'd4, 1'b0, 4'd0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h17161514, 3'd4, 1'b0, 4'd0, 1'b0); tick();
    check("lit_cf_count8", bus.o_byte_count, 5'd8);
    drive(1'b0, 1'b1, 32'h23222120, 3'd4, 1'b1, 4'd3, 1'b0); tick();
    idle();
    check("lit_cf_count", bus.o_byte_count, 5'd9);
    check("lit_cf_window", bus.o_instruction,
          {8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20, 8'h21, 8'h22, 8'h23, 56'h0});

    // full window and ready threshold
    drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, $urandom, 3'd4, 1'b0, 4'd0, 1'b0); tick();
    end
    idle();
    check("lit_full_ready12", bus.o_fetch_ready, 1'b1);
    drive(1'b0, 1'b1, 32'h000000ee, 3'd1, 1'b0, 4'd0, 1'b0); tick();
    idle();
    check("lit_full_count13", bus.o_byte_count, 5'd13);
    check("lit_full_ready13", bus.o_fetch_ready, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, $urandom, 3'd4, 1'b0, 4'd0, 1'b0); tick();
    end
    idle();
    check("lit_full_count16", bus.o_byte_count, 5'd16);
    check("lit_full_ready16", bus.o_fetch_ready, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b1); tick();
    idle();
    check("lit_full_error", bus.o_error, 1'b1);
    check("lit_full_valid", bus.o_window_valid, 1'b0);

    // illegal length
    drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h44332211, 3'd4, 1'b0, 4'd0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h00000055, 3'd1, 1'b0, 4'd0, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 4'd7, 1'b0); tick();
    idle();
    check("lit_ill_error", bus.o_error, 1'b1);
    check("lit_ill_count", bus.o_byte_count, 5'd5);
    drive(1'b0, 1'b1, 32'hdeadbeef, 3'd4, 1'b1, 4'd1, 1'b0); tick();
    idle();
    check("lit_ill_frozen", bus.o_instruction, {32'h11223344, 8'h55, 88'h0});
    check("lit_ill_ready", bus.o_fetch_ready, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0); tick();
    idle();
    check("lit_ill_clear", bus.o_error, 1'b0);
    check("lit_ill_count0", bus.o_byte_count, 5'd0);

    // flush priority
    drive(1'b0, 1'b1, 32'h04030201, 3'd4, 1'b0, 4'd0, 1'b0); tick();
    drive(1'b1, 1'b1, 32'h08070605, 3'd4, 1'b1, 4'd2, 1'b0); tick();
    idle();
    check("lit_flush_count", bus.o_byte_count, 5'd0);
    check("lit_flush_valid", bus.o_window_valid, 1'b0);
    check("lit_flush_window", bus.o_instruction, 128'h0);

    // reset mid-PRESENT
    drive(1'b0, 1'b1, 32'h04030201, 3'd4, 1'b0, 4'd0, 1'b0); tick();
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h08070605, 3'd4, 1'b1, 4'd2, 1'b0); tick();
    rst = 1'b0;
    idle();
    check("lit_rst_count", bus.o_byte_count, 5'd0);
    check("lit_rst_valid", bus.o_window_valid, 1'b0);
    check("lit_rst_ready", bus.o_fetch_ready, 1'b1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      sz   = m_q.size();
      fl   = ($urandom_range(0, 99) < (m_err ? 30 : 2));
      fv   = ($urandom_range(0, 99) < 70);
      r    = $urandom_range(0, 99);
      dd   = (r < 30) || (r == 99);
      nm   = ((r >= 30) && (r < 36)) || (r == 99);
      maxl = (sz == 0) ? 1 : ((sz > MAX_INSN_LEN) ? MAX_INSN_LEN : sz);
      if ($urandom_range(0, 9) == 0) dl = 4'($urandom_range(0, 15));
      else                           dl = 4'($urandom_range(1, maxl));
      rst = ($urandom_range(0, 499) == 0);
      drive(fl, fv, $urandom, 3'($urandom_range(1, 4)), dd, dl, nm);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
